// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for the combinational program memory: drives the word address,
// captures returned words and hands them to decode over a valid/ready handshake.
module imem_fetch_ctrl #(
    parameter int unsigned DATA_DEP  = 512,
    parameter int unsigned ADDR_WID  = 30,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_WID-1:0] start_addr,
    input  logic                redir_valid,
    input  logic [ADDR_WID-1:0] redir_addr,
    output logic [ADDR_WID-1:0] mem_addr,
    input  logic [31:0]         mem_rdata,
    output logic [31:0]         inst,
    output logic [ADDR_WID-1:0] inst_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic                busy,
    output logic                halted,
    output logic                fault
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    // One extra bit so the bound compare stays correct for any DATA_DEP up to 2^ADDR_WID.
    localparam logic [ADDR_WID:0] DEP_EXT = (ADDR_WID + 1)'(DATA_DEP);

    logic [1:0]          r_state;
    logic [ADDR_WID-1:0] r_pc;
    logic [31:0]         r_inst;
    logic [ADDR_WID-1:0] r_inst_pc;
    logic                r_inst_valid;

    logic w_accept;
    logic w_free;
    logic w_oob;
    logic w_halt_word;

    assign w_accept    = r_inst_valid && inst_ready;
    assign w_free      = !r_inst_valid || inst_ready;
    assign w_oob       = ({1'b0, r_pc} >= DEP_EXT);
    assign w_halt_word = (mem_rdata == HALT_WORD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pc    <= start_addr;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // A redirect flushes the held word even if decode accepts it this cycle.
                    if (redir_valid) begin
                        r_pc         <= redir_addr;
                        r_inst_valid <= 1'b0;
                    end else if (w_oob) begin
                        r_state <= S_FAULT;
                        if (w_accept) begin
                            r_inst_valid <= 1'b0;
                        end
                    end else if (w_free) begin
                        r_inst       <= mem_rdata;
                        r_inst_pc    <= r_pc;
                        r_inst_valid <= 1'b1;
                        if (w_halt_word) begin
                            r_state <= S_HALT;
                        end else begin
                            r_pc <= r_pc + ADDR_WID'(1);
                        end
                    end
                end
                S_HALT: begin
                    if (redir_valid) begin
                        r_pc         <= redir_addr;
                        r_inst_valid <= 1'b0;
                        r_state      <= S_RUN;
                    end else if (w_accept) begin
                        r_inst_valid <= 1'b0;
                    end
                end
                default: begin
                    // Fault is sticky; only a pending word may still drain.
                    if (w_accept) begin
                        r_inst_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign mem_addr   = r_pc;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_valid = r_inst_valid;
    assign busy       = (r_state == S_RUN);
    assign halted     = (r_state == S_HALT);
    assign fault      = (r_state == S_FAULT);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios plus a randomized
// run scored against a transaction-level model of the delivered instruction stream.
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [29:0] start_addr;
    logic        redir_valid;
    logic [29:0] redir_addr;
    logic [29:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] inst;
    logic [29:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        busy;
    logic        halted;
    logic        fault;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [0:1023];

    assign mem_rdata = (mem_addr < 30'd1024) ? mem[mem_addr[9:0]] : 32'h0;

    imem_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_addr  (start_addr),
        .redir_valid (redir_valid),
        .redir_addr  (redir_addr),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .busy        (busy),
        .halted      (halted),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are observed and inputs changed on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; redir_valid = 1'b0;
        start_addr = '0; redir_addr = '0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic do_start(input logic [29:0] a);
        start = 1'b1; start_addr = a;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({mem_addr, inst, inst_pc} !== 92'h0) begin
            n_fail++; $display("FAIL reset_data: got addr=%0h inst=%0h pc=%0h want 0", mem_addr, inst, inst_pc);
        end
        n_tests++;
        if ({inst_valid, busy, halted, fault} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got v/b/h/f=%b want 0000", {inst_valid, busy, halted, fault});
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_w [0:3];
        exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33; exp_w[3] = 32'h44;
        do_reset();
        inst_ready = 1'b1;
        do_start(30'd0);
        n_tests++;
        if ({inst_valid, busy} !== 2'b01) begin
            n_fail++; $display("FAIL stream_latency: got valid/busy=%b want 01", {inst_valid, busy});
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if ({inst_valid, busy, inst, inst_pc} !== {1'b1, 1'b1, exp_w[i], 30'(i)}) begin
                n_fail++;
                $display("FAIL stream_%0d: got v=%b b=%b inst=%0h pc=%0d want 1 1 %0h %0d",
                         i, inst_valid, busy, inst, inst_pc, exp_w[i], i);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        inst_ready = 1'b1;
        do_start(30'd0);
        inst_ready = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if ({inst_valid, inst, inst_pc, mem_addr} !== {1'b1, 32'h11, 30'd0, 30'd1}) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got v=%b inst=%0h pc=%0d addr=%0d want 1 11 0 1",
                         k, inst_valid, inst, inst_pc, mem_addr);
            end
            if (k < 3) step();
        end
        inst_ready = 1'b1;
        step();
        n_tests++;
        if ({inst_valid, inst, inst_pc, mem_addr} !== {1'b1, 32'h22, 30'd1, 30'd2}) begin
            n_fail++;
            $display("FAIL bp_release: got v=%b inst=%0h pc=%0d addr=%0d want 1 22 1 2",
                     inst_valid, inst, inst_pc, mem_addr);
        end
        step();
        n_tests++;
        if ({inst, inst_pc} !== {32'h33, 30'd2}) begin
            n_fail++; $display("FAIL bp_next: got inst=%0h pc=%0d want 33 2", inst, inst_pc);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        inst_ready = 1'b1;
        do_start(30'd0);
        step(); step();
        n_tests++;
        if (mem_addr !== 30'd2) begin
            n_fail++; $display("FAIL redir_pre: got addr=%0d want 2", mem_addr);
        end
        redir_valid = 1'b1; redir_addr = 30'd10;
        step();
        redir_valid = 1'b0;
        n_tests++;
        if ({inst_valid, mem_addr} !== {1'b0, 30'd10}) begin
            n_fail++; $display("FAIL redir_flush: got v=%b addr=%0d want 0 10", inst_valid, mem_addr);
        end
        step();
        n_tests++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, mem[10], 30'd10}) begin
            n_fail++;
            $display("FAIL redir_target: got v=%b inst=%0h pc=%0d want 1 %0h 10", inst_valid, inst, inst_pc, mem[10]);
        end
    endtask

    task automatic test_halt();
        logic [31:0] saved;
        saved = mem[5];
        mem[5] = 32'hFFFF_FFFF;
        do_reset();
        inst_ready = 1'b1;
        do_start(30'd4);
        step();
        n_tests++;
        if ({inst, inst_pc} !== {mem[4], 30'd4}) begin
            n_fail++; $display("FAIL halt_pre: got inst=%0h pc=%0d want %0h 4", inst, inst_pc, mem[4]);
        end
        step();
        n_tests++;
        if ({inst_valid, inst, inst_pc, halted, busy, mem_addr} !== {1'b1, 32'hFFFF_FFFF, 30'd5, 1'b1, 1'b0, 30'd5}) begin
            n_fail++;
            $display("FAIL halt_word: got v=%b inst=%0h pc=%0d h=%b b=%b addr=%0d want 1 ffffffff 5 1 0 5",
                     inst_valid, inst, inst_pc, halted, busy, mem_addr);
        end
        start = 1'b1; start_addr = 30'd7;
        step();
        start = 1'b0;
        n_tests++;
        if ({inst_valid, halted, mem_addr} !== {1'b0, 1'b1, 30'd5}) begin
            n_fail++; $display("FAIL halt_hold: got v=%b h=%b addr=%0d want 0 1 5", inst_valid, halted, mem_addr);
        end
        redir_valid = 1'b1; redir_addr = 30'd0;
        step();
        redir_valid = 1'b0;
        n_tests++;
        if ({busy, halted, inst_valid, mem_addr} !== {1'b1, 1'b0, 1'b0, 30'd0}) begin
            n_fail++; $display("FAIL halt_exit: got b=%b h=%b v=%b addr=%0d want 1 0 0 0", busy, halted, inst_valid, mem_addr);
        end
        step();
        n_tests++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h11, 30'd0}) begin
            n_fail++; $display("FAIL halt_refetch: got v=%b inst=%0h pc=%0d want 1 11 0", inst_valid, inst, inst_pc);
        end
        mem[5] = saved;
    endtask

    task automatic test_bounds();
        do_reset();
        inst_ready = 1'b1;
        do_start(30'd510);
        step();
        n_tests++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 30'd510, mem[510]}) begin
            n_fail++; $display("FAIL bnd_510: got v=%b pc=%0d inst=%0h want 1 510 %0h", inst_valid, inst_pc, inst, mem[510]);
        end
        step();
        n_tests++;
        if ({inst_valid, inst_pc, inst, mem_addr} !== {1'b1, 30'd511, mem[511], 30'd512}) begin
            n_fail++;
            $display("FAIL bnd_511: got v=%b pc=%0d inst=%0h addr=%0d want 1 511 %0h 512", inst_valid, inst_pc, inst, mem_addr, mem[511]);
        end
        step();
        n_tests++;
        if ({fault, busy, inst_valid, mem_addr} !== {1'b1, 1'b0, 1'b0, 30'd512}) begin
            n_fail++; $display("FAIL bnd_fault: got f=%b b=%b v=%b addr=%0d want 1 0 0 512", fault, busy, inst_valid, mem_addr);
        end
        start = 1'b1; start_addr = 30'd0; redir_valid = 1'b1; redir_addr = 30'd3;
        step(); step();
        start = 1'b0; redir_valid = 1'b0;
        n_tests++;
        if ({fault, busy, inst_valid, mem_addr} !== {1'b1, 1'b0, 1'b0, 30'd512}) begin
            n_fail++; $display("FAIL bnd_sticky: got f=%b b=%b v=%b addr=%0d want 1 0 0 512", fault, busy, inst_valid, mem_addr);
        end
        do_reset();
        n_tests++;
        if ({fault, busy, halted, inst_valid, mem_addr, inst, inst_pc} !== 96'h0) begin
            n_fail++; $display("FAIL bnd_clear: got f=%b b=%b h=%b v=%b addr=%0d want all 0", fault, busy, halted, inst_valid, mem_addr);
        end
        // A pending word survives entry to FAULT and drains on accept.
        inst_ready = 1'b0;
        do_start(30'd511);
        step(); step();
        n_tests++;
        if ({fault, inst_valid, inst_pc} !== {1'b1, 1'b1, 30'd511}) begin
            n_fail++; $display("FAIL bnd_pending: got f=%b v=%b pc=%0d want 1 1 511", fault, inst_valid, inst_pc);
        end
        inst_ready = 1'b1;
        step();
        n_tests++;
        if ({fault, inst_valid} !== 2'b10) begin
            n_fail++; $display("FAIL bnd_drain: got f=%b v=%b want 1 0", fault, inst_valid);
        end
        do_reset();
        do_start(30'd600);
        n_tests++;
        if ({busy, inst_valid, mem_addr} !== {1'b1, 1'b0, 30'd600}) begin
            n_fail++; $display("FAIL bnd_far_run: got b=%b v=%b addr=%0d want 1 0 600", busy, inst_valid, mem_addr);
        end
        step();
        n_tests++;
        if ({fault, inst_valid} !== 2'b10) begin
            n_fail++; $display("FAIL bnd_far_fault: got f=%b v=%b want 1 0", fault, inst_valid);
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        inst_ready = 1'b0;
        do_start(30'd0);
        step(); step();
        n_tests++;
        if ({inst_valid, busy} !== 2'b11) begin
            n_fail++; $display("FAIL rstmid_pre: got v=%b b=%b want 1 1", inst_valid, busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if ({inst_valid, busy, halted, fault, mem_addr, inst, inst_pc} !== 96'h0) begin
            n_fail++;
            $display("FAIL rstmid_clear: got v=%b b=%b h=%b f=%b addr=%0d inst=%0h pc=%0d want all 0",
                     inst_valid, busy, halted, fault, mem_addr, inst, inst_pc);
        end
    endtask

    // Model: accepted words must be consecutive addresses from the last start/redirect
    // target, each carrying mem[] of that address, and decode never starves more than
    // one cycle after a start or redirect.
    task automatic test_random();
        int unsigned exp_addr;
        int          starve;
        logic        acc;
        do_reset();
        inst_ready = 1'b1;
        exp_addr = $urandom_range(0, 100);
        do_start(30'(exp_addr));
        starve = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            starve = inst_valid ? 0 : starve + 1;
            n_tests++;
            if (starve > 1) begin
                n_fail++; $display("FAIL rnd_starve cyc=%0d: got %0d idle cycles want <=1", cyc, starve);
            end
            inst_ready  = ($urandom_range(0, 3) != 0);
            redir_valid = ($urandom_range(0, 15) == 0) || (exp_addr > 400);
            redir_addr  = 30'($urandom_range(0, 300));
            acc = inst_valid && inst_ready;
            if (acc) begin
                n_tests++;
                if ({inst_pc, inst} !== {30'(exp_addr), mem[exp_addr]}) begin
                    n_fail++;
                    $display("FAIL rnd_accept cyc=%0d: got pc=%0d inst=%0h want %0d %0h",
                             cyc, inst_pc, inst, exp_addr, mem[exp_addr]);
                end
                exp_addr++;
            end
            if (redir_valid) begin
                exp_addr = int'(redir_addr);
                starve   = 0;
            end
            step();
        end
        redir_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_addr = '0;
        redir_valid = 1'b0; redir_addr = '0; inst_ready = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom & 32'h7FFF_FFFF;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_bounds();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Fetch sequencer for the combinational program memory `mem_prog`, which takes a word address and returns 32-bit read data.
- Drives the memory word address and captures each returned word into an output register.
- Presents captured instructions to the downstream decode stage with a valid/ready handshake.
- Handles start, redirect (branch/jump), halt-word detection and out-of-bounds fault.
- Sits between `mem_prog` and the core's decode stage.

Parameters:
- DATA_DEP, 512, number of valid words in program memory; legal addresses are 0..DATA_DEP-1.
- ADDR_WID, 30, word-address width; matches the `mem_prog` addr port.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetching.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins fetching at start_addr; honoured only in IDLE.
- start_addr  in  ADDR_WID  first fetch address.
- redir_valid  in  1  redirect request.
- redir_addr  in  ADDR_WID  redirect target.
- mem_addr  out  ADDR_WID  word address to `mem_prog`; equals internal pc.
- mem_rdata  in  32  combinational read data from `mem_prog`.
- inst  out  32  captured instruction.
- inst_pc  out  ADDR_WID  address inst was fetched from.
- inst_valid  out  1  inst/inst_pc hold a valid instruction.
- inst_ready  in  1  downstream accepts when inst_valid && inst_ready.
- busy  out  1  high in RUN.
- halted  out  1  high in HALT.
- fault  out  1  high in FAULT.

Behaviour:
Reset values:
- pc, mem_addr, inst, inst_pc = 0.
- inst_valid, busy, halted, fault = 0.
- state = IDLE.
- rst mid-operation discards any held instruction; no partial state survives.

States: IDLE, RUN, HALT, FAULT. Outputs are registered.
- mem_addr = pc at all times.
- busy = (state==RUN), halted = (state==HALT), fault = (state==FAULT).

IDLE:
- start=1: pc <= start_addr, go to RUN.
- redir_valid is ignored.

RUN, per cycle, in priority order:
1. redir_valid=1:
   - pc <= redir_addr, inst_valid <= 0 (held instruction flushed, even if inst_ready=1 that cycle).
   - No capture this cycle; stay in RUN.
2. pc >= DATA_DEP (unsigned compare):
   - No capture, go to FAULT.
   - inst_valid keeps its value until the pending instruction is accepted.
3. Output register free (inst_valid==0 or inst_ready==1):
   - inst <= mem_rdata, inst_pc <= pc, inst_valid <= 1, pc <= pc+1.
   - If mem_rdata == HALT_WORD: capture it (presented downstream), pc is not incremented, go to HALT.
4. Otherwise (stalled): hold pc and all outputs.

Timing and throughput:
- Latency: 1 cycle from pc to inst_valid.
- Sustained throughput: 1 instruction per cycle when inst_ready is held high.
- pc increments modulo 2^ADDR_WID; in practice the bounds check triggers FAULT first.

HALT:
- No fetch. The captured HALT_WORD remains valid until accepted (inst_valid <= 0 on accept).
- redir_valid=1: pc <= redir_addr, inst_valid <= 0, go to RUN.
- start is ignored.

FAULT:
- No fetch. A pending valid instruction drains normally on accept.
- start and redir_valid are ignored; exit only via rst.

Simultaneous events:
- redir_valid together with an accept in RUN: redirect wins, no capture.
- start together with redir_valid in IDLE: start is taken.
- start_addr >= DATA_DEP: enters RUN, then FAULT on the next cycle; no instruction is ever presented.

Test Plan:
1. Memory words 0..3 = 32'h11, 32'h22, 32'h33, 32'h44; start with start_addr=0, inst_ready=1 -> inst_valid rises 1 cycle after start is taken; inst = 11, 22, 33, 44 on consecutive cycles with inst_pc = 0..3; busy=1.
2. Backpressure: same program, inst_ready=0 for 3 cycles after the first capture -> inst=32'h11, inst_pc=0 held; mem_addr stays 1; on release, 32'h22 follows on the next cycle with no word skipped or duplicated.
3. Redirect: running at pc=2, redir_valid=1 with redir_addr=10 and inst_ready=1 -> inst_valid=0 next cycle; the following cycle inst_pc=10, inst=word[10]; word[2] never accepted.
4. Halt: word[5]=32'hFFFF_FFFF, start at 4 -> inst_pc 4 then 5 (inst=FFFF_FFFF), halted=1, mem_addr stays 5; then redir_valid with redir_addr=0 -> RUN, fetches word[0].
5. Bounds: DATA_DEP=512, start_addr=510, inst_ready=1 -> instructions at 510 and 511 delivered, then fault=1, busy=0, no capture at 512; start and redirect ignored; rst clears fault, state IDLE, all outputs 0.
6. Reset mid-run: rst=1 while inst_valid=1 and stalled -> next cycle inst_valid=0, pc=0, busy=0, halted=0, fault=0.
